cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arb_pkg.sv | 6 +
 rtl/cache_arbiter.sv | 57 +++++
 tb/tb_cache_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared types and default widths for the cache arbiter
package cache_arb_pkg;
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;
endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: arbitrates I-cache and D-cache line traffic onto one memory port
// Define CACHE_ARB_RR_EN for round-robin tie breaking; default is fixed D-cache priority
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    state_t state, next_state;
    logic   d_req, d_first;
    assign d_req = d_pmem_read | d_pmem_write;
`ifdef CACHE_ARB_RR_EN
    logic last_d;
    always_ff @(posedge clk or posedge rst)
        if (rst) last_d <= 1'b0;
        else if (state != IDLE && pmem_resp) last_d <= state == SERVE_D;
    // D loses a tie only when it owned the previous completed transaction
    assign d_first = !(i_pmem_read && last_d);
`else
    assign d_first = 1'b1;
`endif
    always_comb
        next_state = state == IDLE ? (d_req && d_first ? SERVE_D :
                                      i_pmem_read      ? SERVE_I :
                                      d_req            ? SERVE_D : IDLE)
                   : pmem_resp ? IDLE : state;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next_state;
    assign pmem_read    = state == SERVE_I ? i_pmem_read : state == SERVE_D ? d_pmem_read : 1'b0;
    assign pmem_write   = state == SERVE_D && d_pmem_write;
    assign pmem_address = state == SERVE_I ? i_pmem_address : d_pmem_address;
    assign pmem_wdata   = d_pmem_wdata;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign i_pmem_resp  = state == SERVE_I && pmem_resp;
    assign d_pmem_resp  = state == SERVE_D && pmem_resp;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: scoreboard bench for cache_arbiter with a latency-programmable memory model
module tb_cache_arbiter;
    logic         clk = 0, rst = 1;
    logic         i_pmem_read = 0, d_pmem_read = 0, d_pmem_write = 0;
    logic [31:0]  i_pmem_address = 0, d_pmem_address = 0;
    logic [255:0] d_pmem_wdata = 0;
    logic [255:0] i_pmem_rdata, d_pmem_rdata, pmem_wdata;
    logic         i_pmem_resp, d_pmem_resp, pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata = 0;
    logic         pmem_resp = 0;

    typedef struct {logic [31:0] addr; logic rd; logic wr; logic [255:0] wdata; int cyc;} cmd_t;
    typedef struct {logic side_d; logic [255:0] irdata; logic [255:0] drdata; int cyc;} resp_t;
    cmd_t  exp_q[$], obs_q[$];
    resp_t resp_q[$];
    int tests = 0, fails = 0, cyc = 0, mem_cnt = 0, mem_lat = 5;
    logic prev_cmd = 0;

    cache_arbiter dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // memory answers mem_lat cycles after a command appears; monitor logs command starts and responses
    always @(negedge clk) begin
        if (rst || !(pmem_read || pmem_write) || pmem_resp) begin
            mem_cnt = 0;
            pmem_resp = 0;
        end else begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                pmem_resp = 1;
                pmem_rdata = {8{pmem_address}};
            end
        end
        #1;
        if ((pmem_read || pmem_write) && !prev_cmd)
            obs_q.push_back('{pmem_address, pmem_read, pmem_write, pmem_wdata, cyc});
        if (i_pmem_resp) resp_q.push_back('{1'b0, i_pmem_rdata, d_pmem_rdata, cyc});
        if (d_pmem_resp) resp_q.push_back('{1'b1, i_pmem_rdata, d_pmem_rdata, cyc});
        prev_cmd = pmem_read || pmem_write;
    end

    task automatic wait_resp(input int n);
        for (int k = 0; k < 60 && resp_q.size() < n; k++) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #2;
        tests += 4;
        if (pmem_read !== 1'b0) begin fails++; $display("FAIL reset_pmem_read got %b want 0", pmem_read); end
        if (pmem_write !== 1'b0) begin fails++; $display("FAIL reset_pmem_write got %b want 0", pmem_write); end
        if (i_pmem_resp !== 1'b0) begin fails++; $display("FAIL reset_i_resp got %b want 0", i_pmem_resp); end
        if (d_pmem_resp !== 1'b0) begin fails++; $display("FAIL reset_d_resp got %b want 0", d_pmem_resp); end
        @(posedge clk);
        #1 rst = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_i_only;
        int n;
        cmd_t e, o;
        resp_t r;
        mem_lat = 5;
        @(posedge clk);
        #1;
        n = cyc;
        i_pmem_address = 32'h0000_1000;
        i_pmem_read = 1;
        exp_q.push_back('{32'h0000_1000, 1'b1, 1'b0, '0, n + 1});
        @(negedge clk);
        #2;
        tests++;
        if (pmem_read !== 1'b0) begin fails++; $display("FAIL i_latency pmem_read got %b want 0 in request cycle", pmem_read); end
        wait_resp(1);
        i_pmem_read = 0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (resp_q.size() != 1 || obs_q.size() != 1) begin
            fails++;
            $display("FAIL i_only_counts resp %0d cmd %0d want 1 1", resp_q.size(), obs_q.size());
            resp_q.delete(); obs_q.delete(); exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            r = resp_q.pop_front();
            tests += 6;
            if (o.addr !== e.addr) begin fails++; $display("FAIL i_addr got %h want %h", o.addr, e.addr); end
            if (o.rd !== e.rd || o.wr !== e.wr) begin fails++; $display("FAIL i_cmd got rd%b wr%b want rd%b wr%b", o.rd, o.wr, e.rd, e.wr); end
            if (o.cyc != e.cyc) begin fails++; $display("FAIL i_start got %0d want %0d", o.cyc, e.cyc); end
            if (r.cyc != n + 5) begin fails++; $display("FAIL i_resp_cycle got %0d want %0d", r.cyc, n + 5); end
            if (r.side_d !== 1'b0) begin fails++; $display("FAIL i_resp_side got d=%b want 0", r.side_d); end
            if (r.irdata !== {8{e.addr}} || r.drdata !== {8{e.addr}}) begin fails++; $display("FAIL i_rdata_bcast got %h want %h", r.irdata[31:0], e.addr); end
        end
    endtask

    task automatic test_d_write;
        cmd_t e, o;
        resp_t r;
        mem_lat = 3;
        @(posedge clk);
        #1;
        d_pmem_address = 32'h0000_2040;
        d_pmem_wdata = {32{8'hA5}};
        d_pmem_write = 1;
        exp_q.push_back('{32'h0000_2040, 1'b0, 1'b1, {32{8'hA5}}, cyc + 1});
        wait_resp(1);
        d_pmem_write = 0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (resp_q.size() != 1 || obs_q.size() != 1) begin
            fails++;
            $display("FAIL d_write_counts resp %0d cmd %0d want 1 1", resp_q.size(), obs_q.size());
            resp_q.delete(); obs_q.delete(); exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            r = resp_q.pop_front();
            tests += 5;
            if (o.addr !== e.addr) begin fails++; $display("FAIL dw_addr got %h want %h", o.addr, e.addr); end
            if (o.rd !== e.rd || o.wr !== e.wr) begin fails++; $display("FAIL dw_cmd got rd%b wr%b want rd%b wr%b", o.rd, o.wr, e.rd, e.wr); end
            if (o.wdata !== e.wdata) begin fails++; $display("FAIL dw_wdata got %h want %h", o.wdata, e.wdata); end
            if (o.cyc != e.cyc) begin fails++; $display("FAIL dw_start got %0d want %0d", o.cyc, e.cyc); end
            if (r.side_d !== 1'b1) begin fails++; $display("FAIL dw_resp_side got d=%b want 1", r.side_d); end
        end
    endtask

    task automatic test_simultaneous;
        cmd_t e, o;
        resp_t r0, r1;
        mem_lat = 3;
        @(posedge clk);
        #1;
        d_pmem_address = 32'h0000_3000;
        i_pmem_address = 32'h0000_4000;
        d_pmem_read = 1;
        i_pmem_read = 1;
        exp_q.push_back('{32'h0000_3000, 1'b1, 1'b0, '0, cyc + 1});
        exp_q.push_back('{32'h0000_4000, 1'b1, 1'b0, '0, 0});
        wait_resp(1);
        d_pmem_read = 0;
        wait_resp(2);
        i_pmem_read = 0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (resp_q.size() != 2 || obs_q.size() != 2) begin
            fails++;
            $display("FAIL sim_counts resp %0d cmd %0d want 2 2", resp_q.size(), obs_q.size());
            resp_q.delete(); obs_q.delete(); exp_q.delete();
        end else begin
            r0 = resp_q.pop_front();
            r1 = resp_q.pop_front();
            tests += 3;
            if (r0.side_d !== 1'b1 || r1.side_d !== 1'b0) begin fails++; $display("FAIL sim_order got d=%b,%b want 1,0", r0.side_d, r1.side_d); end
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o.addr !== e.addr || o.cyc != e.cyc) begin fails++; $display("FAIL sim_first got %h@%0d want %h@%0d", o.addr, o.cyc, e.addr, e.cyc); end
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o.addr !== e.addr || o.cyc != r0.cyc + 2) begin fails++; $display("FAIL sim_second got %h@%0d want %h@%0d", o.addr, o.cyc, e.addr, r0.cyc + 2); end
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] want;
        resp_t r;
        cmd_t o;
`ifdef CACHE_ARB_RR_EN
        want = 3'b101;
`else
        want = 3'b111;
`endif
        mem_lat = 2;
        @(posedge clk);
        #1;
        d_pmem_address = 32'h0000_5000;
        i_pmem_address = 32'h0000_6000;
        d_pmem_read = 1;
        i_pmem_read = 1;
        for (int k = 0; k < 3; k++)
            exp_q.push_back('{want[2-k] ? 32'h0000_5000 : 32'h0000_6000, 1'b1, 1'b0, '0, 0});
        wait_resp(3);
        d_pmem_read = 0;
        i_pmem_read = 0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (resp_q.size() != 3 || obs_q.size() != 3) begin
            fails++;
            $display("FAIL b2b_counts resp %0d cmd %0d want 3 3", resp_q.size(), obs_q.size());
            resp_q.delete(); obs_q.delete(); exp_q.delete();
        end else
            for (int k = 0; k < 3; k++) begin
                r = resp_q.pop_front();
                o = obs_q.pop_front();
                tests += 2;
                if (r.side_d !== want[2-k]) begin fails++; $display("FAIL b2b_grant%0d got d=%b want %b", k, r.side_d, want[2-k]); end
                if (o.addr !== exp_q[0].addr) begin fails++; $display("FAIL b2b_addr%0d got %h want %h", k, o.addr, exp_q[0].addr); end
                void'(exp_q.pop_front());
            end
    endtask

    task automatic test_rw_both;
        cmd_t o;
        mem_lat = 2;
        @(posedge clk);
        #1;
        d_pmem_address = 32'h0000_7000;
        d_pmem_read = 1;
        d_pmem_write = 1;
        wait_resp(1);
        d_pmem_read = 0;
        d_pmem_write = 0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (obs_q.size() != 1 || resp_q.size() != 1) begin
            fails++;
            $display("FAIL rw_counts resp %0d cmd %0d want 1 1", resp_q.size(), obs_q.size());
        end else begin
            o = obs_q.pop_front();
            tests++;
            if (o.rd !== 1'b1 || o.wr !== 1'b1 || o.addr !== 32'h0000_7000) begin fails++; $display("FAIL rw_forward got rd%b wr%b %h want rd1 wr1 00007000", o.rd, o.wr, o.addr); end
        end
        resp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid;
        mem_lat = 1000;
        @(posedge clk);
        #1;
        d_pmem_address = 32'h0000_8000;
        d_pmem_write = 1;
        repeat (3) @(posedge clk);
        #3;
        tests++;
        if (pmem_write !== 1'b1) begin fails++; $display("FAIL mid_write_active got %b want 1", pmem_write); end
        rst = 1;
        #1;
        tests += 3;
        if (pmem_write !== 1'b0) begin fails++; $display("FAIL mid_async_write got %b want 0", pmem_write); end
        if (pmem_read !== 1'b0) begin fails++; $display("FAIL mid_async_read got %b want 0", pmem_read); end
        if (d_pmem_resp !== 1'b0 || i_pmem_resp !== 1'b0) begin fails++; $display("FAIL mid_async_resp got i%b d%b want 0 0", i_pmem_resp, d_pmem_resp); end
        d_pmem_write = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        mem_lat = 2;
        repeat (5) @(posedge clk);
        #1;
        tests += 2;
        if (resp_q.size() != 0) begin fails++; $display("FAIL mid_no_resp got %0d responses want 0", resp_q.size()); end
        if (obs_q.size() != 1 || obs_q[0].addr !== 32'h0000_8000) begin fails++; $display("FAIL mid_cmd got %0d commands want 1 at 00008000", obs_q.size()); end
        obs_q.delete();
        resp_q.delete();
    endtask

    initial begin
        test_reset;
        test_i_only;
        test_d_write;
        test_simultaneous;
        test_back_to_back;
        test_rw_both;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
